// File: rtl/register_store_unit.sv
// Store/push unit: snapshots one register and writes it out as 1 or 2 big-endian
// bytes on a valid/ready memory write port, optionally pre-decrementing SP.
package register_types;
  typedef logic [15:0] addr_t;
  typedef enum logic [3:0] {
    NAME_NONE = 4'd0,
    NAME_M    = 4'd1,
    NAME_V    = 4'd2,
    NAME_OP0H = 4'd3,
    NAME_OP0L = 4'd4,
    NAME_OP1H = 4'd5,
    NAME_OP1L = 4'd6,
    NAME_OP0  = 4'd7,
    NAME_OP1  = 4'd8,
    NAME_X    = 4'd9,
    NAME_SP   = 4'd10,
    NAME_FP   = 4'd11,
    NAME_GP   = 4'd12,
    NAME_IP   = 4'd13,
    NAME_AP   = 4'd14
  } name_t;
endpackage

module register_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  register_types::name_t req_src,
  input  logic                  req_push,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [7:0]            M,
  input  logic [7:0]            V,
  input  logic [15:0]           OP0,
  input  logic [15:0]           OP1,
  input  logic [ADDR_W-1:0]     X,
  input  logic [ADDR_W-1:0]     SP,
  input  logic [ADDR_W-1:0]     FP,
  input  logic [ADDR_W-1:0]     GP,
  input  logic [ADDR_W-1:0]     IP,
  input  logic [ADDR_W-1:0]     AP,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  sp_wr_en,
  output logic [ADDR_W-1:0]     sp_wr_data,
  output logic                  done,
  output logic                  err
);
  import register_types::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid-side holds its payload stable until that edge.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BYTE_HI = 2'd1;
  localparam logic [1:0] BYTE_LO = 2'd2;

  logic [1:0]        state;
  logic [7:0]        lo_q;
  logic [ADDR_W-1:0] base_q;
  logic              push_q;

  logic              src_ok;
  logic              src_two;
  logic [15:0]       src_val;
  logic [ADDR_W-1:0] base;
  logic              accept;

  always_comb begin
    src_ok  = 1'b1;
    src_two = 1'b0;
    src_val = 16'h0000;
    case (req_src)
      NAME_M:    src_val = {8'h00, M};
      NAME_V:    src_val = {8'h00, V};
      NAME_OP0H: src_val = {8'h00, OP0[15:8]};
      NAME_OP0L: src_val = {8'h00, OP0[7:0]};
      NAME_OP1H: src_val = {8'h00, OP1[15:8]};
      NAME_OP1L: src_val = {8'h00, OP1[7:0]};
      NAME_OP0:  begin src_two = 1'b1; src_val = OP0;       end
      NAME_OP1:  begin src_two = 1'b1; src_val = OP1;       end
      NAME_X:    begin src_two = 1'b1; src_val = X[15:0];   end
      NAME_SP:   begin src_two = 1'b1; src_val = SP[15:0];  end
      NAME_FP:   begin src_two = 1'b1; src_val = FP[15:0];  end
      NAME_GP:   begin src_two = 1'b1; src_val = GP[15:0];  end
      NAME_IP:   begin src_two = 1'b1; src_val = IP[15:0];  end
      NAME_AP:   begin src_two = 1'b1; src_val = AP[15:0];  end
      default:   src_ok = 1'b0;
    endcase
  end

  // Push addresses use the SP value present at acceptance, wrapping modulo 2^ADDR_W.
  always_comb begin
    base = req_addr;
    if (req_push) base = SP - (src_two ? ADDR_W'(2) : ADDR_W'(1));
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= 8'h00;
      sp_wr_en     <= 1'b0;
      sp_wr_data   <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      lo_q         <= 8'h00;
      base_q       <= '0;
      push_q       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      sp_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!src_ok) begin
              err <= 1'b1;
            end else begin
              lo_q         <= src_val[7:0];
              base_q       <= base;
              push_q       <= req_push;
              mem_wr_valid <= 1'b1;
              mem_wr_addr  <= base;
              mem_wr_data  <= src_two ? src_val[15:8] : src_val[7:0];
              req_ready    <= 1'b0;
              state        <= src_two ? BYTE_HI : BYTE_LO;
            end
          end
        end
        BYTE_HI: begin
          if (mem_wr_ready) begin
            mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
            mem_wr_data <= lo_q;
            state       <= BYTE_LO;
          end
        end
        BYTE_LO: begin
          if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
            req_ready    <= 1'b1;
            done         <= 1'b1;
            state        <= IDLE;
            if (push_q) begin
              sp_wr_en   <= 1'b1;
              sp_wr_data <= base_q;
            end
          end
        end
        default: begin
          mem_wr_valid <= 1'b0;
          req_ready    <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_register_store_unit.sv
// Bench for register_store_unit: table of store/push vectors, a byte-write
// scoreboard, and hand sequences for stalls, back-to-back and mid-request reset.
module tb_register_store_unit;
  import register_types::*;

  typedef struct {
    name_t       src;
    logic        push;
    logic [15:0] addr;
    logic [15:0] sp;
    logic        err;
    logic        two;
    logic [15:0] base;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  name_t       req_src = NAME_NONE;
  logic        req_push = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  M = 8'h00, V = 8'h00;
  logic [15:0] OP0 = 16'h0, OP1 = 16'h0;
  logic [15:0] X = 16'h0, SP = 16'h0, FP = 16'h0, GP = 16'h0, IP = 16'h0, AP = 16'h0;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b1;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        sp_wr_en;
  logic [15:0] sp_wr_data;
  logic        done;
  logic        err;

  register_store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_push(req_push), .req_addr(req_addr),
    .M(M), .V(V), .OP0(OP0), .OP1(OP1),
    .X(X), .SP(SP), .FP(FP), .GP(GP), .IP(IP), .AP(AP),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data),
    .done(done), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          done_seen = 0;
  logic [23:0] exp_q[$];
  bit          rdy_rand = 1'b0;
  bit          rdy_fix = 1'b1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;
  vec_t        vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // memory-side ready driver
  always @(posedge clk) begin
    #1;
    mem_wr_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  // scoreboard: byte writes popped from exp_q as they are handshaken
  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", mem_wr_valid, 1);
        check("hold_addr", mem_wr_addr, prev_addr);
        check("hold_data", mem_wr_data, prev_data);
      end
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_q.size() == 0) check("spurious_write", {mem_wr_addr, mem_wr_data}, 0);
        else begin
          e = exp_q.pop_front();
          check("write", {mem_wr_addr, mem_wr_data}, e);
        end
      end
      if (sp_wr_en && !done) check("sp_without_done", 1, 0);
      if (done) done_seen++;
      prev_stall = mem_wr_valid && !mem_wr_ready;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end
  end

  // driver tasks
  task automatic start_req(input vec_t v);
    M = 8'h5A; V = 8'hC3; OP0 = 16'hBEEF; OP1 = 16'h1277;
    X = 16'h1234; FP = 16'hF00D; GP = 16'h6A6B; IP = 16'h0102; AP = 16'hA0A1;
    SP = v.sp;
    req_src = v.src; req_push = v.push; req_addr = v.addr;
    req_valid = 1'b1;
    if (!v.err) begin
      if (v.two) begin
        exp_q.push_back({v.base, v.hi});
        exp_q.push_back({16'(v.base + 16'd1), v.lo});
      end else begin
        exp_q.push_back({v.base, v.lo});
      end
    end
  endtask

  task automatic finish_accept();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src = name_t'(4'($urandom_range(0, 15)));
    req_push = 1'($urandom);
    req_addr = 16'($urandom);
    M = 8'($urandom); V = 8'($urandom); OP0 = 16'($urandom); OP1 = 16'($urandom);
    X = 16'($urandom); SP = 16'($urandom); FP = 16'($urandom);
    GP = 16'($urandom); IP = 16'($urandom); AP = 16'($urandom);
  endtask

  task automatic wait_end(output int cyc, output bit got_done, output bit got_err);
    cyc = 0; got_done = 0; got_err = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (done || err) begin
        got_done = done; got_err = err;
        break;
      end
    end
    if (!got_done && !got_err) check("timeout", 0, 1);
  endtask

  task automatic end_check(input vec_t v, input int cyc, input bit gd, input bit ge, input bit lat);
    check("err", ge, v.err);
    check("done", gd, !v.err);
    check("sp_wr_en", sp_wr_en, v.push && !v.err);
    if (v.push && !v.err) check("sp_wr_data", sp_wr_data, v.base);
    check("req_ready_end", req_ready, 1);
    check("wr_valid_end", mem_wr_valid, 0);
    check("queue_drained", exp_q.size(), 0);
    if (lat) check("latency", cyc, v.err ? 1 : (v.two ? 3 : 2));
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input bit lat);
    int cyc; bit gd; bit ge;
    @(negedge clk);
    check("req_ready_start", req_ready, 1);
    start_req(v);
    finish_accept();
    wait_end(cyc, gd, ge);
    end_check(v, cyc, gd, ge, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc; bit gd; bit ge; int ds;
    //           src        push  addr      sp        err  two  base      hi     lo
    vecs[0]  = '{NAME_OP0,  1'b0, 16'h1000, 16'h2000, 1'b0, 1'b1, 16'h1000, 8'hBE, 8'hEF};
    vecs[1]  = '{NAME_M,    1'b1, 16'h0000, 16'h2000, 1'b0, 1'b0, 16'h1FFF, 8'h00, 8'h5A};
    vecs[2]  = '{NAME_X,    1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 8'h12, 8'h34};
    vecs[3]  = '{NAME_NONE, 1'b0, 16'h1000, 16'h2000, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[4]  = '{NAME_OP1L, 1'b0, 16'h0010, 16'h2000, 1'b0, 1'b0, 16'h0010, 8'h00, 8'h77};
    vecs[5]  = '{NAME_SP,   1'b1, 16'h0000, 16'h3000, 1'b0, 1'b1, 16'h2FFE, 8'h30, 8'h00};
    vecs[6]  = '{NAME_V,    1'b0, 16'hFFFF, 16'h2000, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hC3};
    vecs[7]  = '{NAME_OP0H, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hBE};
    vecs[8]  = '{NAME_OP0L, 1'b0, 16'h4000, 16'h2000, 1'b0, 1'b0, 16'h4000, 8'h00, 8'hEF};
    vecs[9]  = '{NAME_OP1H, 1'b1, 16'h0000, 16'h0101, 1'b0, 1'b0, 16'h0100, 8'h00, 8'h12};
    vecs[10] = '{NAME_OP1,  1'b0, 16'hFFFF, 16'h2000, 1'b0, 1'b1, 16'hFFFF, 8'h12, 8'h77};
    vecs[11] = '{NAME_FP,   1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1, 16'h7FFE, 8'hF0, 8'h0D};
    vecs[12] = '{NAME_GP,   1'b0, 16'h0000, 16'h2000, 1'b0, 1'b1, 16'h0000, 8'h6A, 8'h6B};
    vecs[13] = '{NAME_IP,   1'b1, 16'h0000, 16'h0002, 1'b0, 1'b1, 16'h0000, 8'h01, 8'h02};
    vecs[14] = '{NAME_AP,   1'b0, 16'h1234, 16'h2000, 1'b0, 1'b1, 16'h1234, 8'hA0, 8'hA1};
    vecs[15] = '{name_t'(4'hF), 1'b1, 16'h0000, 16'h2000, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[16] = '{NAME_SP,   1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_wr_valid", mem_wr_valid, 0);
    check("rst_wr_addr", mem_wr_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    check("rst_sp_wr_en", sp_wr_en, 0);
    check("rst_sp_wr_data", sp_wr_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // memory always ready: exact latency
    for (int i = 0; i < 17; i++) run_vec(vecs[i], 1'b1);
    // random memory backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 17; i++) run_vec(vecs[i], 1'b0);
    rdy_rand = 1'b0;

    // stall: ready low for several cycles during the high byte
    rdy_fix = 1'b0;
    @(negedge clk);
    start_req(vecs[2]);
    finish_accept();
    @(negedge clk);
    check("stall_valid", mem_wr_valid, 1);
    check("stall_addr", mem_wr_addr, 16'hFFFF);
    check("stall_data", mem_wr_data, 8'h12);
    repeat (2) @(posedge clk);
    rdy_fix = 1'b1;
    wait_end(cyc, gd, ge);
    end_check(vecs[2], cyc, gd, ge, 1'b0);

    // back-to-back: second request offered in the done cycle
    @(negedge clk);
    start_req(vecs[4]);
    finish_accept();
    wait_end(cyc, gd, ge);
    end_check(vecs[4], cyc, gd, ge, 1'b1);
    start_req(vecs[5]);
    finish_accept();
    wait_end(cyc, gd, ge);
    end_check(vecs[5], cyc, gd, ge, 1'b1);

    // reset after the high-byte handshake
    @(negedge clk);
    start_req(vecs[2]);
    finish_accept();
    @(negedge clk);
    check("pre_rst_valid", mem_wr_valid, 1);
    @(posedge clk);
    #2;
    ds = done_seen;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", mem_wr_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_sp_wr_en", sp_wr_en, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", mem_wr_addr, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_no_done", done_seen, ds);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", mem_wr_valid, 0);
    run_vec(vecs[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/register_store_unit.md
Name: register_store_unit

Overview:
Moves register contents out to byte-wide memory. It is the store/push counterpart of the register file, which loads registers from memory.
- The microcode sequencer issues one store request naming a source register.
- The block snapshots that register and emits 1 or 2 byte writes on a valid/ready memory write port.
- For pushes, it computes addresses from SP and hands back the new SP value.

Parameters:
ADDR_W, 16, address width; must equal the width of register_types::addr_t.

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  reset; asynchronous assert, active-low.
req_valid  in  1  store request valid.
req_ready  out  1  block can accept a request.
req_src  in  name_t  register to store.
req_push  in  1  1 = push to stack via SP; 0 = store at req_addr.
req_addr  in  ADDR_W  base address, used when req_push=0.
M, V  in  8  register file outputs.
OP0, OP1  in  16  register file outputs.
X, SP, FP, GP, IP, AP  in  ADDR_W  register file outputs.
mem_wr_valid  out  1  byte write valid.
mem_wr_ready  in  1  memory accepts the byte.
mem_wr_addr  out  ADDR_W  byte address.
mem_wr_data  out  8  byte data.
sp_wr_en  out  1  one-cycle pulse: load sp_wr_data into SP.
sp_wr_data  out  ADDR_W  new SP value.
done  out  1  one-cycle pulse: request completed.
err  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, sp_wr_en=0, sp_wr_data=0, done=0, err=0. All outputs are registered.
- Acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - On acceptance the block captures the source value, byte count n, and base address. Later register changes do not affect the request.
- Source widths:
  - n=1: M, V, OP0H (=OP0[15:8]), OP0L (=OP0[7:0]), OP1H, OP1L.
  - n=2: OP0, OP1, X, SP, FP, GP, IP, AP.
  - Any other name_t value (including the no-destination value) is invalid.
- Invalid source:
  - No memory write, no SP update.
  - err=1 for exactly the cycle after acceptance; req_ready stays 1.
- Addressing:
  - req_push=0: base = req_addr.
  - req_push=1: base = SP - n (pre-decrement; the captured SP is used).
  - All address arithmetic is modulo 2^ADDR_W; e.g. SP=0x0000, n=2 gives base 0xFFFE.
- Byte order is big-endian for n=2: high byte at base, low byte at base+1 (wraps: 0xFFFF+1 = 0x0000).
- FSM: IDLE -> BYTE_HI (n=2 only) -> BYTE_LO -> IDLE. An n=1 request goes IDLE -> BYTE_LO directly.
- Memory handshake:
  - mem_wr_valid rises the cycle after acceptance. req_ready=0 outside IDLE.
  - A byte completes on an edge with mem_wr_valid && mem_wr_ready. Addr and data are held stable while waiting.
  - After BYTE_HI completes, BYTE_LO presents the next byte in the very next cycle; valid stays high, with no bubble.
  - Memory may hold mem_wr_ready low indefinitely; the block waits with no timeout.
- Completion:
  - In the cycle after the last byte's handshake: done=1, mem_wr_valid=0, req_ready=1.
  - If req_push=1, sp_wr_en=1 in that same cycle with sp_wr_data = base.
  - A new request may be accepted in that done cycle (back-to-back).
- Latency with memory always ready:
  - Acceptance at edge 0, byte writes at edges 1 (and 2).
  - done high during cycle 2 for n=1, or cycle 3 for n=2.
- Pushing SP itself: the value stored is the pre-decrement SP.
- Reset mid-operation: the request is aborted; outputs take their reset values immediately (async). A partially written byte pair is left as-is and no SP update occurs.
- req_src, req_push and req_addr are ignored when no request is accepted.

Test Plan:
1. Store OP0=0xBEEF, req_push=0, req_addr=0x1000, mem_wr_ready=1 -> writes (0x1000,0xBE) at edge 1 and (0x1001,0xEF) at edge 2; done in cycle 3; sp_wr_en never asserted.
2. Push M=0x5A with SP=0x2000 -> one write (0x1FFF,0x5A); done and sp_wr_en together with sp_wr_data=0x1FFF.
3. Push X=0x1234 with SP=0x0001 and mem_wr_ready held low for 3 cycles -> addr/data held at (0xFFFF,0x12) while stalled, then (0x0000,0x34); sp_wr_data=0xFFFF.
4. Invalid req_src (no-destination value) -> err pulse one cycle; mem_wr_valid stays 0; req_ready stays 1.
5. Back-to-back: store OP1L=0x77 to 0x0010, then push SP=0x3000 issued in the done cycle -> writes (0x0010,0x77), then (0x2FFE,0x30), (0x2FFF,0x00); sp_wr_data=0x2FFE.
6. Assert rst_n low mid-request, after the BYTE_HI handshake -> mem_wr_valid drops immediately; no done, no sp_wr_en; req_ready=1 after reset release.
